// File: rtl/icache_nway_control_if.sv
// Fetch-side and arbiter-side signals of the N-way instruction-cache controller.
interface icache_nway_control_if #(
  parameter int unsigned WAYS     = 4,
  parameter int unsigned SETS     = 16,
  parameter int unsigned OFFSET_W = 5
);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned WAY_W = $clog2(WAYS);

  logic              mem_read;
  logic [31:0]       mem_address;
  logic              flush;
  logic              mem_resp;
  logic [WAY_W-1:0]  hit_way;
  logic              busy;
  logic [IDX_W-1:0]  data_index;
  logic [WAYS-1:0]   data_we;
  logic              pmem_read;
  logic [31:0]       pmem_address;
  logic              pmem_resp;

  // Environment side: fetch stage plus memory arbiter.
  modport master (
    output mem_read, mem_address, flush, pmem_resp,
    input  mem_resp, hit_way, busy, data_index, data_we, pmem_read, pmem_address
  );

  // Cache controller side.
  modport slave (
    input  mem_read, mem_address, flush, pmem_resp,
    output mem_resp, hit_way, busy, data_index, data_we, pmem_read, pmem_address
  );
endinterface

// File: rtl/icache_nway_control.sv
// N-way set-associative I-cache controller: tag/valid/tree-PLRU state,
// zero-latency hit, line refill through the arbiter and whole-cache flush.
module icache_nway_control #(
  parameter int unsigned WAYS     = 4,
  parameter int unsigned SETS     = 16,
  parameter int unsigned OFFSET_W = 5
) (
  input logic                  clk,
  input logic                  rst,
  icache_nway_control_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 32 - IDX_W - OFFSET_W;
  localparam int unsigned WAY_W = $clog2(WAYS);

  typedef enum logic [1:0] {S_CHECK, S_REFILL, S_FLUSH} state_e;

  state_e             state_q, state_d;
  logic [WAY_W-1:0]   victim_q, victim_d;
  logic [31:0]        pmem_addr_q, pmem_addr_d;
  logic [IDX_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               flush_pending_q, flush_pending_d;

  logic [WAYS-1:0]    valid_q [SETS];
  logic [WAYS-2:0]    plru_q  [SETS];
  logic [TAG_W-1:0]   tag_q   [SETS][WAYS];

  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic               unused_offset;

  logic               hit;
  logic [WAY_W-1:0]   hit_way_c;
  logic               any_inv;
  logic [WAY_W-1:0]   inv_way;

  logic               mem_resp_c;
  logic [WAYS-1:0]    data_we_c;
  logic               fill_we;
  logic               plru_we;
  logic [WAYS-2:0]    plru_new;
  logic               flush_clear;

  assign idx           = bus.mem_address[IDX_W+OFFSET_W-1:OFFSET_W];
  assign tag           = bus.mem_address[31:IDX_W+OFFSET_W];
  assign unused_offset = ^bus.mem_address[OFFSET_W-1:0];

  // Tree nodes are heap-ordered from 0; children of n are 2n+1 and 2n+2,
  // and a node bit of 1 steers the victim search to the right subtree.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] row);
    logic [WAY_W:0] n;
    n = '0;
    for (int unsigned l = 0; l < WAY_W; l++) begin
      n = {n[WAY_W-1:0], 1'b0} + (WAY_W+1)'(1) + (WAY_W+1)'(row[n[WAY_W-1:0]]);
    end
    return WAY_W'(n - (WAY_W+1)'(WAYS-1));
  endfunction

  // Point every node on the path to 'way' toward the opposite subtree.
  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] row,
                                                 input logic [WAY_W-1:0] way);
    logic [WAY_W:0] n;
    logic           dir;
    n = '0;
    for (int unsigned l = 0; l < WAY_W; l++) begin
      dir = way[WAY_W-1-l];
      row[n[WAY_W-1:0]] = ~dir;
      n = {n[WAY_W-1:0], 1'b0} + (WAY_W+1)'(1) + (WAY_W+1)'(dir);
    end
    return row;
  endfunction

  // Tag lookup across all ways of the addressed set, plus lowest invalid way.
  always_comb begin
    hit       = 1'b0;
    hit_way_c = '0;
    any_inv   = 1'b0;
    inv_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        hit       = 1'b1;
        hit_way_c = WAY_W'(w);
      end
    end
    for (int unsigned w = WAYS; w > 0; w--) begin
      if (!valid_q[idx][w-1]) begin
        any_inv = 1'b1;
        inv_way = WAY_W'(w-1);
      end
    end
  end

  // Next-state and per-cycle control for CHECK / REFILL / FLUSH.
  always_comb begin
    state_d         = state_q;
    victim_d        = victim_q;
    pmem_addr_d     = pmem_addr_q;
    flush_cnt_d     = flush_cnt_q;
    flush_pending_d = flush_pending_q;
    mem_resp_c      = 1'b0;
    data_we_c       = '0;
    fill_we         = 1'b0;
    plru_we         = 1'b0;
    plru_new        = plru_q[idx];
    flush_clear     = 1'b0;
    case (state_q)
      S_CHECK: begin
        if (bus.flush || flush_pending_q) begin
          state_d         = S_FLUSH;
          flush_cnt_d     = '0;
          flush_pending_d = 1'b0;
        end else if (bus.mem_read) begin
          if (hit) begin
            mem_resp_c = 1'b1;
            plru_we    = 1'b1;
            plru_new   = plru_touch(plru_q[idx], hit_way_c);
          end else begin
            victim_d    = any_inv ? inv_way : plru_victim(plru_q[idx]);
            pmem_addr_d = {tag, idx, {OFFSET_W{1'b0}}};
            state_d     = S_REFILL;
          end
        end
      end
      S_REFILL: begin
        if (bus.flush) flush_pending_d = 1'b1;
        if (bus.pmem_resp) begin
          data_we_c[victim_q] = 1'b1;
          fill_we             = 1'b1;
          plru_we             = 1'b1;
          plru_new            = plru_touch(plru_q[idx], victim_q);
          state_d             = S_CHECK;
        end
      end
      S_FLUSH: begin
        flush_clear = 1'b1;
        if (flush_cnt_q == IDX_W'(SETS-1)) state_d = S_CHECK;
        else flush_cnt_d = flush_cnt_q + IDX_W'(1);
      end
      default: state_d = S_CHECK;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_CHECK;
      victim_q        <= '0;
      pmem_addr_q     <= '0;
      flush_cnt_q     <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      victim_q        <= victim_d;
      pmem_addr_q     <= pmem_addr_d;
      flush_cnt_q     <= flush_cnt_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  // Valid and PLRU arrays: cleared by reset and by the flush walk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else if (flush_clear) begin
      valid_q[flush_cnt_q] <= '0;
      plru_q[flush_cnt_q]  <= '0;
    end else begin
      if (fill_we) valid_q[idx][victim_q] <= 1'b1;
      if (plru_we) plru_q[idx]            <= plru_new;
    end
  end

  // Tag array: contents are meaningless until the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_we) tag_q[idx][victim_q] <= tag;
  end

  assign bus.mem_resp     = mem_resp_c;
  assign bus.hit_way      = mem_resp_c ? hit_way_c : '0;
  assign bus.busy         = (state_q != S_CHECK);
  assign bus.data_index   = rst ? '0 : idx;
  assign bus.data_we      = data_we_c;
  assign bus.pmem_read    = (state_q == S_REFILL);
  assign bus.pmem_address = pmem_addr_q;
endmodule

// File: tb/tb_icache_nway_control.sv
// Directed bench for icache_nway_control with WAYS=4, SETS=16, OFFSET_W=5.
module tb_icache_nway_control;
  logic clk = 1'b0;
  logic rst;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  icache_nway_control_if #(.WAYS(4), .SETS(16), .OFFSET_W(5)) bus ();

  icache_nway_control #(.WAYS(4), .SETS(16), .OFFSET_W(5)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One fetch: a hit answers in the current cycle; a miss refills with the
  // arbiter answering on the third REFILL cycle, then hits the cycle after.
  task automatic do_read(input logic [31:0] addr, input bit is_hit,
                         input logic [1:0] exp_way);
    logic [3:0] exp_we;
    bus.mem_address = addr;
    bus.mem_read    = 1'b1;
    #1;
    check_eq("data_index", 32'(bus.data_index), 32'(addr[8:5]));
    if (is_hit) begin
      check_eq("hit_resp", 32'(bus.mem_resp), 32'd1);
      check_eq("hit_way", 32'(bus.hit_way), 32'(exp_way));
      check_eq("hit_no_pmem", 32'(bus.pmem_read), 32'd0);
    end else begin
      check_eq("miss_resp", 32'(bus.mem_resp), 32'd0);
      step();
      check_eq("refill_pmem_read", 32'(bus.pmem_read), 32'd1);
      check_eq("refill_addr", bus.pmem_address, addr & 32'hFFFF_FFE0);
      check_eq("refill_busy", 32'(bus.busy), 32'd1);
      for (int i = 0; i < 2; i++) begin
        check_eq("refill_no_we", 32'(bus.data_we), 32'd0);
        step();
      end
      bus.pmem_resp = 1'b1;
      #1;
      exp_we = 4'b0001 << exp_way;
      check_eq("refill_we", 32'(bus.data_we), 32'(exp_we));
      step();
      bus.pmem_resp = 1'b0;
      #1;
      check_eq("after_fill_resp", 32'(bus.mem_resp), 32'd1);
      check_eq("after_fill_way", 32'(bus.hit_way), 32'(exp_way));
      check_eq("after_fill_busy", 32'(bus.busy), 32'd0);
    end
    step();
    bus.mem_read = 1'b0;
  endtask

  // Counts FLUSH cycles (bounded); also flags any response during the walk.
  task automatic count_flush(input string tag);
    int unsigned cnt;
    int unsigned bad;
    cnt = 0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.busy) break;
      if (bus.mem_resp || bus.pmem_read) bad++;
      cnt++;
      bus.flush = (i == 5);
      step();
    end
    bus.flush = 1'b0;
    #1;
    check_eq(tag, cnt, 32'd16);
    check_eq({tag, "_quiet"}, bad, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst             = 1'b1;
    bus.mem_read    = 1'b0;
    bus.mem_address = 32'h0000_1234;
    bus.flush       = 1'b0;
    bus.pmem_resp   = 1'b0;
    #1;
    check_eq("rst_resp", 32'(bus.mem_resp), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_pmem_read", 32'(bus.pmem_read), 32'd0);
    check_eq("rst_pmem_addr", bus.pmem_address, 32'd0);
    check_eq("rst_data_index", 32'(bus.data_index), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Cold miss then fill of set 1 in way order.
    do_read(32'h0000_1234, 1'b0, 2'd0);
    do_read(32'h0000_1420, 1'b0, 2'd1);
    do_read(32'h0000_1620, 1'b0, 2'd2);
    do_read(32'h0000_1820, 1'b0, 2'd3);

    // Back-to-back hits alternating two lines, ending on 0x1220.
    bus.mem_read = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.mem_address = (i % 2 == 0) ? 32'h0000_1220 : 32'h0000_1420;
      #1;
      check_eq("b2b_resp", 32'(bus.mem_resp), 32'd1);
      check_eq("b2b_way", 32'(bus.hit_way), (i % 2 == 0) ? 32'd0 : 32'd1);
      check_eq("b2b_no_pmem", 32'(bus.pmem_read), 32'd0);
      step();
    end
    bus.mem_read = 1'b0;

    // PLRU eviction: way 2, then way 1 (0x1420), 0x1220 survives.
    do_read(32'h0000_1A20, 1'b0, 2'd2);
    do_read(32'h0000_1620, 1'b0, 2'd1);
    do_read(32'h0000_1220, 1'b1, 2'd0);

    // Arbiter response outside a refill has no effect.
    bus.pmem_resp = 1'b1;
    #1;
    check_eq("stray_pmem_resp_we", 32'(bus.data_we), 32'd0);
    step();
    bus.pmem_resp = 1'b0;
    #1;
    check_eq("stray_pmem_resp_busy", 32'(bus.busy), 32'd0);

    // Flush with the cache holding lines; read held throughout.
    bus.mem_address = 32'h0000_1220;
    bus.mem_read    = 1'b1;
    bus.flush       = 1'b1;
    #1;
    check_eq("flush_prio_resp", 32'(bus.mem_resp), 32'd0);
    step();
    bus.flush = 1'b0;
    count_flush("flush_len");
    do_read(32'h0000_1220, 1'b0, 2'd0);
    do_read(32'h0000_1A20, 1'b0, 2'd1);

    // Flush during refill: fill completes, then the flush walk, then a miss.
    bus.mem_address = 32'h0000_2040;
    bus.mem_read    = 1'b1;
    #1;
    check_eq("fdr_miss", 32'(bus.mem_resp), 32'd0);
    step();
    bus.flush = 1'b1;
    #1;
    check_eq("fdr_pmem_read", 32'(bus.pmem_read), 32'd1);
    step();
    bus.flush = 1'b0;
    step();
    bus.pmem_resp = 1'b1;
    #1;
    check_eq("fdr_we", 32'(bus.data_we), 32'b0001);
    step();
    bus.pmem_resp = 1'b0;
    #1;
    check_eq("fdr_pending_resp", 32'(bus.mem_resp), 32'd0);
    step();
    count_flush("fdr_flush_len");
    do_read(32'h0000_2040, 1'b0, 2'd0);

    // Asynchronous reset in the middle of a refill.
    bus.mem_address = 32'h0000_3000;
    bus.mem_read    = 1'b1;
    step();
    check_eq("rst_mid_pre", 32'(bus.pmem_read), 32'd1);
    #2;
    bus.pmem_resp = 1'b1;
    rst           = 1'b1;
    #1;
    check_eq("rst_mid_pmem_read", 32'(bus.pmem_read), 32'd0);
    check_eq("rst_mid_we", 32'(bus.data_we), 32'd0);
    check_eq("rst_mid_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_mid_addr", bus.pmem_address, 32'd0);
    check_eq("rst_mid_resp", 32'(bus.mem_resp), 32'd0);
    step();
    bus.pmem_resp = 1'b0;
    bus.mem_read  = 1'b0;
    rst           = 1'b0;
    step();
    do_read(32'h0000_1234, 1'b0, 2'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
